// File: rtl/vreg_wb_arbiter_pkg.sv
// vreg_pkg: shared types for the vector register write-back path.
//   LANES/LANE_W/ADDR_W : register geometry (3 lanes x 18 bits, 16 registers)
//   vreg_t              : one packed vector register, lane 0 in the low bits
//   wb_req_t            : one queued write (destination address + data)
//   wb_src_e            : write-back requester identity
package vreg_pkg;

  localparam int unsigned LANES  = 3;
  localparam int unsigned LANE_W = 18;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREGS  = 1 << ADDR_W;

  typedef logic [LANES-1:0][LANE_W-1:0] vreg_t;
  typedef logic [ADDR_W-1:0]            vaddr_t;

  typedef struct packed {
    vaddr_t addr;
    vreg_t  data;
  } wb_req_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

  function automatic wb_src_e wb_other(input wb_src_e s);
    return (s == WB_ALU) ? WB_MEM : WB_ALU;
  endfunction

endpackage

// File: rtl/vreg_wb_arbiter_if.sv
// vreg_wb_arbiter_if: bus between the two write-back requesters, the arbiter
// and the register-file write port / hazard logic.
//   alu_valid/alu_ready/alu_addr/alu_data : ALU write-back request
//   mem_valid/mem_ready/mem_addr/mem_data : memory-load write-back request
//   RegWriteW/wa3w/wd3                    : registered register-file write port
//   pend_mask                             : one bit per register with a queued write
// Modports: slave = arbiter side, master = requesters / consumers side.
interface vreg_wb_arbiter_if;
  import vreg_pkg::*;

  logic                 alu_valid;
  logic                 alu_ready;
  logic [ADDR_W-1:0]    alu_addr;
  vreg_t                alu_data;

  logic                 mem_valid;
  logic                 mem_ready;
  logic [ADDR_W-1:0]    mem_addr;
  vreg_t                mem_data;

  logic                 RegWriteW;
  logic [ADDR_W-1:0]    wa3w;
  vreg_t                wd3;
  logic [NREGS-1:0]     pend_mask;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready,
    output RegWriteW, wa3w, wd3, pend_mask
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready,
    input  RegWriteW, wa3w, wd3, pend_mask
  );

endinterface

// File: rtl/vreg_wb_arbiter_fifo.sv
// wb_fifo: DEPTH-entry circular buffer of write-back requests.
//   clk, rst              : clock, asynchronous active-high reset
//   push_valid/push_ready : push handshake; ready depends only on the stored count
//   push_data             : request to enqueue
//   pop                   : dequeue the head (ignored when empty)
//   head                  : oldest queued request
//   count                 : number of queued requests
//   nxt_vld/nxt_addr      : per-entry valid/address as they will be after this edge
module wb_fifo
  import vreg_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push_valid,
  output logic                             push_ready,
  input  wb_req_t                          push_data,
  input  logic                             pop,
  output wb_req_t                          head,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic [DEPTH-1:0]                 nxt_vld,
  output logic [DEPTH-1:0][ADDR_W-1:0]     nxt_addr
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_req_t          store_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push_ready = (cnt_q < CW'(DEPTH)) && !rst;
  assign push       = push_valid && push_ready;
  assign do_pop     = pop && (cnt_q != '0);
  assign head       = store_q[rd_q];
  assign count      = cnt_q;

  // Push never targets the entry being popped: a push needs count < DEPTH,
  // so wr_q == rd_q with both active would require an empty FIFO to pop.
  always_comb begin
    nxt_vld = vld_q;
    if (do_pop) nxt_vld[rd_q] = 1'b0;
    if (push)   nxt_vld[wr_q] = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      nxt_addr[i] = store_q[i].addr;
      if (push && (wr_q == PW'(i))) nxt_addr[i] = push_data.addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= nxt_vld;
      if (push)   wr_q <= bump(wr_q);
      if (do_pop) rd_q <= bump(rd_q);
      unique case ({push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) store_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/vreg_wb_arbiter.sv
// vreg_wb_arbiter: shares the vector register file's single write port between
// the ALU and memory-load write-back paths. Each path queues into its own
// wb_fifo; one head is granted per cycle into the registered write port.
//   clk, rst : clock, asynchronous active-high reset
//   wb       : vreg_wb_arbiter_if.slave (requests, write port, pend_mask)
// Build option WB_RR_EN: defined = round-robin between heads when both are
// valid; undefined = fixed priority, memory over ALU.
module vreg_wb_arbiter
  import vreg_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  vreg_wb_arbiter_if.slave       wb
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_req_t                          alu_push, mem_push;
  wb_req_t                          alu_head, mem_head, win;
  logic [CW-1:0]                    alu_cnt, mem_cnt;
  logic                             alu_hv, mem_hv;
  logic                             alu_pop, mem_pop, grant;
  logic [DEPTH-1:0]                 alu_nvld, mem_nvld;
  logic [DEPTH-1:0][ADDR_W-1:0]     alu_naddr, mem_naddr;
  logic [NREGS-1:0]                 pend_nxt;

  logic                             regwrite_q;
  vaddr_t                           wa3w_q;
  vreg_t                            wd3_q;
  logic [NREGS-1:0]                 pend_q;

  assign alu_push = '{addr: wb.alu_addr, data: wb.alu_data};
  assign mem_push = '{addr: wb.mem_addr, data: wb.mem_data};

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (wb.alu_valid),
    .push_ready (wb.alu_ready),
    .push_data  (alu_push),
    .pop        (alu_pop),
    .head       (alu_head),
    .count      (alu_cnt),
    .nxt_vld    (alu_nvld),
    .nxt_addr   (alu_naddr)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (wb.mem_valid),
    .push_ready (wb.mem_ready),
    .push_data  (mem_push),
    .pop        (mem_pop),
    .head       (mem_head),
    .count      (mem_cnt),
    .nxt_vld    (mem_nvld),
    .nxt_addr   (mem_naddr)
  );

  assign alu_hv = (alu_cnt != '0);
  assign mem_hv = (mem_cnt != '0);

`ifdef WB_RR_EN
  wb_src_e rr_q, rr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= WB_ALU;
    else     rr_q <= rr_d;
  end

  always_comb begin
    alu_pop = 1'b0;
    mem_pop = 1'b0;
    rr_d    = rr_q;
    if (alu_hv && mem_hv) begin
      if (rr_q == WB_ALU) alu_pop = 1'b1;
      else                mem_pop = 1'b1;
    end else begin
      alu_pop = alu_hv;
      mem_pop = mem_hv;
    end
    if (alu_pop)      rr_d = wb_other(WB_ALU);
    else if (mem_pop) rr_d = wb_other(WB_MEM);
  end
`else
  always_comb begin
    mem_pop = mem_hv;
    alu_pop = alu_hv && !mem_hv;
  end
`endif

  // pend_mask is built from the post-edge queue contents (plus the write being
  // loaded into the port) so the registered mask matches the registered state.
  always_comb begin
    grant    = alu_pop || mem_pop;
    win      = mem_pop ? mem_head : alu_head;
    pend_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alu_nvld[i]) pend_nxt[alu_naddr[i]] = 1'b1;
      if (mem_nvld[i]) pend_nxt[mem_naddr[i]] = 1'b1;
    end
    if (grant) pend_nxt[win.addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      wa3w_q     <= '0;
      wd3_q      <= '0;
      pend_q     <= '0;
    end else begin
      regwrite_q <= grant;
      if (grant) begin
        wa3w_q <= win.addr;
        wd3_q  <= win.data;
      end
      pend_q <= pend_nxt;
    end
  end

  assign wb.RegWriteW = regwrite_q;
  assign wb.wa3w      = wa3w_q;
  assign wb.wd3       = wd3_q;
  assign wb.pend_mask = pend_q;

endmodule

// File: tb/tb_vreg_wb_arbiter.sv
module tb_vreg_wb_arbiter;
  import vreg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vreg_wb_arbiter_if bus ();

  vreg_wb_arbiter #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  localparam vreg_t D2 = {18'h3FFFF, 18'h00000, 18'h2AAAA};
  localparam vreg_t DA = {3{18'h11111}};
  localparam vreg_t DM = {3{18'h33333}};

  // Expected write address per edge (0 = no write expected), and {alu_ready, mem_ready}.
`ifdef WB_RR_EN
  int         sat_wr  [10] = '{0, 1, 3, 1, 3, 1, 3, 1, 3, 0};
  logic [1:0] sat_rdy [6]  = '{2'b11, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  vreg_t      sat_wd2      = DA;
  int         ord_wr  [8]  = '{0, 4, 6, 5, 6, 6, 0, 0};
  logic       ord_ardy[4]  = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
  int         sat_wr  [10] = '{0, 3, 3, 3, 3, 3, 3, 1, 1, 0};
  logic [1:0] sat_rdy [6]  = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
  vreg_t      sat_wd2      = DM;
  int         ord_wr  [8]  = '{0, 6, 6, 6, 6, 4, 5, 0};
  logic       ord_ardy[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int exp_addr);
    if (exp_addr == 0) begin
      chk({tag, ".we"}, 64'(bus.RegWriteW), 64'd0);
    end else begin
      chk({tag, ".we"}, 64'(bus.RegWriteW), 64'd1);
      chk({tag, ".wa"}, 64'(bus.wa3w), 64'(exp_addr));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.alu_valid = 1'b0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
  endtask

  task automatic reset_pulse;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset and idle
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    chk("rst.we",   64'(bus.RegWriteW), 64'd0);
    chk("rst.pend", 64'(bus.pend_mask), 64'd0);
    chk("rst.ardy", 64'(bus.alu_ready), 64'd0);
    chk("rst.mrdy", 64'(bus.mem_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle.ardy", 64'(bus.alu_ready), 64'd1);
    chk("idle.mrdy", 64'(bus.mem_ready), 64'd1);
    chk("idle.wa",   64'(bus.wa3w), 64'd0);
    chk("idle.wd",   64'(bus.wd3), 64'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle.we", 64'(bus.RegWriteW), 64'd0);
    end
    chk("idle.pend", 64'(bus.pend_mask), 64'd0);

    // Single ALU write to r2
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 4'd2;
    bus.alu_data  = D2;
    tick();
    bus.alu_valid = 1'b0;
    chk("one.q.we",   64'(bus.RegWriteW), 64'd0);
    chk("one.q.pend", 64'(bus.pend_mask), 64'h0004);
    tick();
    chk_wr("one.out", 2);
    chk("one.out.wd",   64'(bus.wd3), 64'(D2));
    chk("one.out.pend", 64'(bus.pend_mask), 64'h0004);
    tick();
    chk("one.post.we",   64'(bus.RegWriteW), 64'd0);
    chk("one.post.pend", 64'(bus.pend_mask), 64'd0);
    chk("one.post.wa",   64'(bus.wa3w), 64'd2);
    chk("one.post.wd",   64'(bus.wd3), 64'(D2));

    // Both requesters saturated: ALU->r1, MEM->r3
    reset_pulse();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 4'd1;
    bus.alu_data  = DA;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 4'd3;
    bus.mem_data  = DM;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_wr("sat", sat_wr[k]);
      if (k < 6) begin
        chk("sat.ardy", 64'(bus.alu_ready), 64'(sat_rdy[k][1]));
        chk("sat.mrdy", 64'(bus.mem_ready), 64'(sat_rdy[k][0]));
      end
      if (k == 1) begin
        chk("sat.pend", 64'(bus.pend_mask), 64'h000A);
        chk("sat.wd",   64'(bus.wd3), 64'(sat_wd2));
      end
      if (k == 5) idle_inputs();
    end
    chk("sat.end.pend", 64'(bus.pend_mask), 64'd0);

    // ALU queues r4, r5 while memory keeps pushing r6
    reset_pulse();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 4'd4;
    bus.alu_data  = DA;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 4'd6;
    bus.mem_data  = DM;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_wr("ord", ord_wr[k]);
      if (k < 4) chk("ord.ardy", 64'(bus.alu_ready), 64'(ord_ardy[k]));
      if (k == 0) bus.alu_addr = 4'd5;
      if (k == 1) bus.alu_valid = 1'b0;
      if (k == 3) bus.mem_valid = 1'b0;
    end
    chk("ord.end.pend", 64'(bus.pend_mask), 64'd0);

    // Asynchronous reset with writes queued
    reset_pulse();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 4'd8;
    bus.alu_data  = DA;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 4'd9;
    bus.mem_data  = DM;
    tick();
    tick();
    tick();
    chk_wr("mid.pre", 9);
    chk("mid.pre.pend", 64'(bus.pend_mask), 64'h0300);
    chk("mid.pre.ardy", 64'(bus.alu_ready), 64'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("mid.rst.we",   64'(bus.RegWriteW), 64'd0);
    chk("mid.rst.pend", 64'(bus.pend_mask), 64'd0);
    chk("mid.rst.wa",   64'(bus.wa3w), 64'd0);
    chk("mid.rst.ardy", 64'(bus.alu_ready), 64'd0);
    chk("mid.rst.mrdy", 64'(bus.mem_ready), 64'd0);
    tick();
    rst = 1'b0;
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid.post.we",   64'(bus.RegWriteW), 64'd0);
      chk("mid.post.pend", 64'(bus.pend_mask), 64'd0);
    end
    chk("mid.post.ardy", 64'(bus.alu_ready), 64'd1);
    chk("mid.post.mrdy", 64'(bus.mem_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
